rope_pos_ctrl: RTL and testbench

- Frame-synchronous rope-position controller; sits between the CPU-side rope target (from swervolf_core, already resynchronised to the pixel clock upstream) and the rope icon renderer.
- Latches target updates and moves the displayed rope position toward the target by at most STEP_MAX pixels per frame, only at vertical sync, so there is no tearing.
- Detects a left/right win, holds the win for a fixed number of frames, then re-centres the rope.
- Runs on the 75 MHz pixel clock alongside dtg.

---
 rtl/rope_pkg.sv | 40 ++++
 rtl/rope_pos_ctrl_frame_tick_gen.sv | 27 ++
 rtl/rope_pos_ctrl.sv | 143 ++++++++++++++
 tb/tb_rope_pos_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rope_pkg.sv
// Shared types and helpers for the rope position controller.
//   rope_state_t : game FSM states
//   LOC_W_DEF    : default position width
//   loc_clamp    : clamp a value into [lo, hi]
//   step_toward  : move cur toward tgt by at most step_max, no overshoot
// Helpers work on 32-bit unsigned values, so the distance term has headroom
// beyond LOC_W+1 bits whatever position width the caller uses.
package rope_pkg;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    WIN_L  = 2'd1,
    WIN_R  = 2'd2,
    CENTER = 2'd3
  } rope_state_t;

  localparam int LOC_W_DEF = 10;

  function automatic int unsigned loc_clamp(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic int unsigned step_toward(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned step_max);
    int unsigned d;
    if (tgt >= cur) begin
      d = tgt - cur;
      return cur + ((d < step_max) ? d : step_max);
    end else begin
      d = cur - tgt;
      return cur - ((d < step_max) ? d : step_max);
    end
  endfunction

endpackage

// File: rtl/rope_pos_ctrl_frame_tick_gen.sv
// Vertical-sync edge detector: one-cycle tick when vsync_i enters its active
// level. Holding vsync_i active does not retrigger.
//   clk     : pixel clock
//   rst     : synchronous active-high reset
//   vsync_i : vertical sync, same clock domain
//   tick    : combinational pulse, high on the first active cycle
module frame_tick_gen #(
  parameter logic VSYNC_ACT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  output logic tick
);

  logic act;
  logic vs_q;

  assign act  = (vsync_i == VSYNC_ACT);
  assign tick = act & ~vs_q;

  always_ff @(posedge clk) begin
    if (rst) vs_q <= 1'b0;
    else     vs_q <= act;
  end

endmodule

// File: rtl/rope_pos_ctrl.sv
// Frame-synchronous rope position controller. Latches target updates while
// playing, moves the displayed position toward the target by at most
// STEP_MAX pixels per frame (only at vsync), holds a left/right win for
// WIN_HOLD_FRAMES frames, then walks the rope back to LOC_CENTER.
//   clk, rst    : pixel clock, synchronous active-high reset
//   vsync_i     : vertical sync from the timing generator
//   tgt_valid   : strobe qualifying tgt_loc
//   tgt_loc     : requested rope position
//   game_rst    : strobe restarting the game
//   rope_loc_o  : displayed rope position (registered)
//   frame_tick  : one-cycle pulse per frame
//   win_left    : high while in WIN_L
//   win_right   : high while in WIN_R
//   moving      : position still travelling toward its goal
module rope_pos_ctrl
  import rope_pkg::*;
#(
  parameter int          LOC_W           = LOC_W_DEF,
  parameter int unsigned LOC_MIN         = 0,
  parameter int unsigned LOC_MAX         = 639,
  parameter int unsigned LOC_CENTER      = 320,
  parameter int unsigned STEP_MAX        = 4,
  parameter int unsigned WIN_MARGIN      = 32,
  parameter int unsigned WIN_HOLD_FRAMES = 120,
  parameter logic        VSYNC_ACT       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync_i,
  input  logic             tgt_valid,
  input  logic [LOC_W-1:0] tgt_loc,
  input  logic             game_rst,
  output logic [LOC_W-1:0] rope_loc_o,
  output logic             frame_tick,
  output logic             win_left,
  output logic             win_right,
  output logic             moving
);

  localparam int HOLD_W = (WIN_HOLD_FRAMES > 1) ? $clog2(WIN_HOLD_FRAMES) : 1;

  localparam logic [LOC_W-1:0]  CENTER_LOC = LOC_W'(LOC_CENTER);
  localparam logic [LOC_W-1:0]  WIN_L_TH   = LOC_W'(LOC_MIN + WIN_MARGIN);
  localparam logic [LOC_W-1:0]  WIN_R_TH   = LOC_W'(LOC_MAX - WIN_MARGIN);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(WIN_HOLD_FRAMES - 1);

  rope_state_t       state_q, state_d;
  logic [LOC_W-1:0]  cur_q, cur_d;
  logic [LOC_W-1:0]  tgt_q, tgt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              frame_tick_q;
  logic              tick;

  frame_tick_gen #(
    .VSYNC_ACT (VSYNC_ACT)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .vsync_i (vsync_i),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PLAY;
      cur_q        <= CENTER_LOC;
      tgt_q        <= CENTER_LOC;
      hold_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      tgt_q        <= tgt_d;
      hold_q       <= hold_d;
      frame_tick_q <= tick;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;

    unique case (state_q)
      PLAY: begin
        // A tick steps toward the target held before this edge; a target
        // arriving on the same edge is only seen at the following tick.
        if (tgt_valid) begin
          tgt_d = LOC_W'(loc_clamp(32'(tgt_loc), LOC_MIN, LOC_MAX));
        end
        if (tick) begin
          cur_d = LOC_W'(step_toward(32'(cur_q), 32'(tgt_q), STEP_MAX));
          if (cur_d <= WIN_L_TH) begin
            state_d = WIN_L;
            hold_d  = '0;
          end else if (cur_d >= WIN_R_TH) begin
            state_d = WIN_R;
            hold_d  = '0;
          end
        end
      end
      WIN_L, WIN_R: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) state_d = CENTER;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
      end
      CENTER: begin
        if (tick) begin
          cur_d = LOC_W'(step_toward(32'(cur_q), LOC_CENTER, STEP_MAX));
          if (cur_d == CENTER_LOC) begin
            state_d = PLAY;
            tgt_d   = CENTER_LOC;
          end
        end
      end
      default: state_d = PLAY;
    endcase

    if (game_rst) begin
      state_d = PLAY;
      cur_d   = CENTER_LOC;
      tgt_d   = CENTER_LOC;
      hold_d  = '0;
    end
  end

  always_comb begin
    moving = 1'b0;
    unique case (state_q)
      PLAY:    moving = (cur_q != tgt_q);
      CENTER:  moving = (cur_q != CENTER_LOC);
      default: moving = 1'b0;
    endcase
  end

  assign rope_loc_o = cur_q;
  assign frame_tick = frame_tick_q;
  assign win_left   = (state_q == WIN_L);
  assign win_right  = (state_q == WIN_R);

endmodule

// File: tb/tb_rope_pos_ctrl.sv
module tb_rope_pos_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_i;
  logic       tgt_valid;
  logic [9:0] tgt_loc;
  logic       game_rst;
  logic [9:0] rope_loc_o;
  logic       frame_tick;
  logic       win_left;
  logic       win_right;
  logic       moving;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rope_pos_ctrl #(
    .LOC_W           (10),
    .LOC_MIN         (0),
    .LOC_MAX         (639),
    .LOC_CENTER      (320),
    .STEP_MAX        (4),
    .WIN_MARGIN      (32),
    .WIN_HOLD_FRAMES (120),
    .VSYNC_ACT       (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync_i    (vsync_i),
    .tgt_valid  (tgt_valid),
    .tgt_loc    (tgt_loc),
    .game_rst   (game_rst),
    .rope_loc_o (rope_loc_o),
    .frame_tick (frame_tick),
    .win_left   (win_left),
    .win_right  (win_right),
    .moving     (moving)
  );

  typedef struct {
    logic       vs;
    logic       tv;
    logic [9:0] tl;
    logic       gr;
    logic [9:0] eloc;
    logic       etick;
    logic       ewl;
    logic       ewr;
    logic       emv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int vs, int tv, int tl, int gr,
                              int el, int et, int ewl, int ewr, int em);
    vec_t v;
    v.vs    = vs[0];
    v.tv    = tv[0];
    v.tl    = tl[9:0];
    v.gr    = gr[0];
    v.eloc  = el[9:0];
    v.etick = et[0];
    v.ewl   = ewl[0];
    v.ewr   = ewr[0];
    v.emv   = em[0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int loc, input int wl,
                         input int wr, input int mv);
    chk({tag, ".loc"},    int'(rope_loc_o), loc);
    chk({tag, ".win_l"},  int'(win_left),   wl);
    chk({tag, ".win_r"},  int'(win_right),  wr);
    chk({tag, ".moving"}, int'(moving),     mv);
  endtask

  // One vsync pulse: active for one cycle, then inactive for one cycle.
  task automatic frame();
    vsync_i = 1'b0;
    cycle();
    chk("frame_tick_hi", int'(frame_tick), 1);
    vsync_i = 1'b1;
    cycle();
    chk("frame_tick_lo", int'(frame_tick), 0);
  endtask

  task automatic set_tgt(input int loc);
    tgt_valid = 1'b1;
    tgt_loc   = loc[9:0];
    cycle();
    tgt_valid = 1'b0;
  endtask

  // n frames climbing by 4 from start; win_right first expected on frame n.
  task automatic climb(input int start, input int n);
    for (int k = 1; k <= n; k++) begin
      frame();
      chk_all("climb", start + 4 * k, 0, (k == n) ? 1 : 0, (k == n) ? 0 : 1);
    end
  endtask

  // 120 frames in a win; CENTER is entered on the last one.
  task automatic hold_win(input int loc, input int left);
    for (int n = 1; n <= 120; n++) begin
      frame();
      if (n < 120) chk_all("hold", loc, left, 1 - left, 0);
      else         chk_all("hold_end", loc, 0, 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1; vsync_i = 1'b1; tgt_valid = 1'b0; tgt_loc = '0; game_rst = 1'b0;
    cycle();
    cycle();
    chk_all("reset", 320, 0, 0, 0);
    chk("reset.tick", int'(frame_tick), 0);
    rst = 1'b0;

    //                 vs tv  tl  gr  loc tk wl wr mv
    vecs.push_back(mk(1, 0,   0, 0, 320, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 320, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 320, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 0, 320, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 320, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 0, 320, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 320, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 0, 320, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 330, 0, 320, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0,   0, 0, 324, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0,   0, 0, 324, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0,   0, 0, 328, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0,   0, 0, 328, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0,   0, 0, 330, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 0, 330, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 330, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 0, 330, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 1, 320, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,   0, 0, 320, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0,   0, 0, 320, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0,   0, 0, 316, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0,   0, 1, 320, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 320, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 0, 320, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      vsync_i   = vecs[i].vs;
      tgt_valid = vecs[i].tv;
      tgt_loc   = vecs[i].tl;
      game_rst  = vecs[i].gr;
      cycle();
      chk($sformatf("vec%0d.tick", i), int'(frame_tick), int'(vecs[i].etick));
      chk_all($sformatf("vec%0d", i), int'(vecs[i].eloc), int'(vecs[i].ewl),
              int'(vecs[i].ewr), int'(vecs[i].emv));
    end
    tgt_valid = 1'b0; game_rst = 1'b0; vsync_i = 1'b1;

    // Clamped target 1000 -> 639; win_right on tick 72 at cur=608.
    set_tgt(1000);
    chk("clamp.moving", int'(moving), 1);
    climb(320, 72);
    set_tgt(0);                       // dropped while in WIN_R
    hold_win(608, 0);
    for (int m = 1; m <= 72; m++) begin
      frame();
      chk_all("center", 608 - 4 * m, 0, 0, (m == 72) ? 0 : 1);
    end
    frame();
    chk_all("play_after_center", 320, 0, 0, 0);

    // Walk left into WIN_L, then game_rst mid-win.
    set_tgt(0);
    for (int k = 1; k <= 72; k++) begin
      frame();
      chk_all("fall", 320 - 4 * k, (k == 72) ? 1 : 0, 0, (k == 72) ? 0 : 1);
    end
    for (int k = 0; k < 5; k++) begin
      frame();
      chk_all("winl", 32, 1, 0, 0);
    end
    game_rst = 1'b1;
    cycle();
    game_rst = 1'b0;
    chk_all("game_rst_winl", 320, 0, 0, 0);
    set_tgt(330);
    frame();
    chk_all("after_game_rst", 324, 0, 0, 1);

    // Into CENTER again, then rst mid-CENTER.
    set_tgt(1000);
    climb(324, 71);
    hold_win(608, 0);
    for (int m = 1; m <= 3; m++) frame();
    chk_all("mid_center", 596, 0, 0, 1);
    rst = 1'b1;
    cycle();
    chk_all("rst_center", 320, 0, 0, 0);
    game_rst = 1'b1; vsync_i = 1'b0;
    cycle();
    chk_all("rst_and_game_rst", 320, 0, 0, 0);
    chk("rst_and_game_rst.tick", int'(frame_tick), 0);
    rst = 1'b0; game_rst = 1'b0; vsync_i = 1'b1;
    cycle();
    set_tgt(330);
    frame();
    chk_all("after_rst", 324, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
